fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cm0_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 38 +++
 rtl/fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/cm0_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Holds the fetch FSM state encoding and halfword/word width constants.
package cm0_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  // Little-endian halfword pick: hi=0 -> bits [15:0], hi=1 -> bits [31:16].
  function automatic logic [HALF_W-1:0] sel_half(input logic [WORD_W-1:0] word,
                                                 input logic              hi);
    return hi ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Single-word prefetch buffer: one data word, its word-address tag and a valid bit.
// The tag input is the lookup tag for hit and the stored tag on load.
module fetch_buffer
  import cm0_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              invalidate,
  input  logic [29:0]       tag,
  input  logic [WORD_W-1:0] data,
  input  logic              sel,
  output logic              hit,
  output logic [HALF_W-1:0] halfword
);

  logic [WORD_W-1:0] word_q;
  logic [29:0]       tag_q;
  logic              valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (invalidate) begin
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= data;
      tag_q   <= tag;
      valid_q <= 1'b1;
    end
  end

  assign hit      = valid_q && (tag_q == tag);
  assign halfword = sel_half(word_q, sel);

endmodule

// File: rtl/fetch_unit.sv
// Thumb instruction fetch unit: IDLE/WAIT FSM, PC tracking and memory read port.
// Define FETCH_PREFETCH_BUFFER_EN to add the one-word buffer and its one-cycle hit path.
module fetch_unit
  import cm0_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cu_fetch,
  input  logic              cu_branch,
  input  logic [31:0]       br_target,
  output logic [HALF_W-1:0] instr,
  output logic              instr_valid,
  output logic [31:0]       instr_pc,
  output logic [31:0]       next_pc,
  output logic              fetch_busy,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output fetch_state_e      dbg_state
);

  // Memory handshake: mem_req rises and stays high with mem_addr frozen until the
  // first cycle mem_ack is seen high; that cycle completes the transfer.

  fetch_state_e      state_q, state_d;
  logic [31:0]       req_addr_q;
  logic              discard_q;
  logic              issue_req;
  logic              hit_fetch;
  logic              deliver;
  logic              buf_hit;
  logic [HALF_W-1:0] buf_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue_req = 1'b0;
    hit_fetch = 1'b0;
    deliver   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cu_fetch) begin
          // A same-cycle branch makes the buffer stale, so it always misses.
          if (cu_branch || !buf_hit) begin
            issue_req = 1'b1;
            state_d   = WAIT;
          end else begin
            hit_fetch = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
          deliver = !(discard_q || cu_branch);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pc     <= RESET_PC;
      instr_pc    <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      req_addr_q  <= RESET_PC & ~32'h3;
      discard_q   <= 1'b0;
    end else begin
      instr_valid <= hit_fetch || deliver;
      if (hit_fetch)    instr <= buf_half;
      else if (deliver) instr <= sel_half(mem_rdata, next_pc[1]);
      if (hit_fetch || deliver) instr_pc <= next_pc;
      if (cu_branch)                 next_pc <= br_target & ~32'h1;
      else if (hit_fetch || deliver) next_pc <= next_pc + 32'd2;
      if (issue_req) req_addr_q <= (cu_branch ? br_target : next_pc) & ~32'h3;
      // A redirect during WAIT poisons the in-flight response until its ack.
      discard_q <= (state_q == WAIT) && !mem_ack && (discard_q || cu_branch);
    end
  end

`ifdef FETCH_PREFETCH_BUFFER_EN
  logic [29:0] buf_tag;
  assign buf_tag = deliver ? req_addr_q[31:2] : next_pc[31:2];

  fetch_buffer u_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (deliver),
    .invalidate (cu_branch),
    .tag        (buf_tag),
    .data       (mem_rdata),
    .sel        (next_pc[1]),
    .hit        (buf_hit),
    .halfword   (buf_half)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_half = '0;
`endif

  assign mem_req    = (state_q == WAIT);
  assign fetch_busy = (state_q == WAIT);
  assign mem_addr   = req_addr_q;
  assign dbg_state  = state_q;

endmodule
